// File: rtl/iob_acc_bank.sv
// Multi-channel accumulator bank with an in-order dump-and-clear stream.
// Optional saturating arithmetic with sticky per-channel flags: define IOB_ACC_BANK_SAT_EN.

module iob_acc_bank_ch #(
  parameter int                 DATA_W  = 21,
  parameter int                 INCR_W  = 21,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              add_en,
  input  logic              clr_en,
  input  logic [INCR_W-1:0] incr,
  output logic [DATA_W-1:0] acc,
  output logic              sat
);

`ifdef IOB_ACC_BANK_SAT_EN
  // One extra bit exposes the carry that signals overflow.
  logic [DATA_W:0] sum;
  assign sum = {1'b0, acc} + (DATA_W+1)'(incr);

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i || clr_en) begin
        acc <= RST_VAL;
        sat <= 1'b0;
      end else if (add_en) begin
        if (sum[DATA_W]) begin
          acc <= '1;
          sat <= 1'b1;
        end else begin
          acc <= sum[DATA_W-1:0];
        end
      end
    end
  end
`else
  logic [DATA_W-1:0] sum;
  assign sum = acc + DATA_W'(incr);
  assign sat = 1'b0;

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i || clr_en) acc <= RST_VAL;
      else if (add_en)     acc <= sum;
    end
  end
`endif

endmodule

module iob_acc_bank #(
  parameter int                 N_CH    = 4,
  parameter int                 CH_W    = 2,
  parameter int                 DATA_W  = 21,
  parameter int                 INCR_W  = 21,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CH_W-1:0]   in_ch_i,
  input  logic [INCR_W-1:0] in_incr_i,
  input  logic              dump_i,
  output logic              busy_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CH_W-1:0]   out_ch_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_sat_o,
  input  logic [CH_W-1:0]   rd_ch_i,
  output logic [DATA_W-1:0] rd_data_o
);

  typedef enum logic {IDLE, DUMP} state_t;

  state_t                         state;
  logic [CH_W-1:0]                idx;
  logic [N_CH-1:0][DATA_W-1:0]    acc;
  logic [N_CH-1:0]                sat;
  logic [N_CH-1:0]                add_en;
  logic [N_CH-1:0]                clr_en;
  logic                           accept;
  logic                           hs;

  assign in_ready_o  = (state == IDLE);
  assign busy_o      = (state == DUMP);
  assign out_valid_o = busy_o;
  assign out_ch_o    = idx;
  assign accept      = in_valid_i & in_ready_o;
  assign hs          = out_valid_o & out_ready_i;

  // Out-of-range channel indices match no lane, so they are accepted and dropped.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign add_en[c] = accept & (in_ch_i == CH_W'(c));
    assign clr_en[c] = hs & (idx == CH_W'(c));

    iob_acc_bank_ch #(
      .DATA_W  (DATA_W),
      .INCR_W  (INCR_W),
      .RST_VAL (RST_VAL)
    ) u_ch (
      .clk_i  (clk_i),
      .cke_i  (cke_i),
      .rst_i  (rst_i),
      .add_en (add_en[c]),
      .clr_en (clr_en[c]),
      .incr   (in_incr_i),
      .acc    (acc[c]),
      .sat    (sat[c])
    );
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        state <= IDLE;
        idx   <= '0;
      end else begin
        case (state)
          IDLE: if (dump_i) begin
            state <= DUMP;
            idx   <= '0;
          end
          DUMP: if (out_ready_i) begin
            if (idx == CH_W'(N_CH-1)) begin
              state <= IDLE;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    out_data_o = '0;
    out_sat_o  = 1'b0;
    rd_data_o  = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (idx == CH_W'(c)) begin
        out_data_o = acc[c];
        out_sat_o  = sat[c];
      end
      if (rd_ch_i == CH_W'(c)) rd_data_o = acc[c];
    end
  end

endmodule

// File: tb/tb_iob_acc_bank.sv
// Randomized + directed bench for iob_acc_bank against a behavioural model of the bank.
module tb_iob_acc_bank;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       cke, rst, in_valid, dump, out_ready;
  logic [1:0] in_ch, rd_ch;
  logic [7:0] in_incr;
  logic       in_ready, busy, out_valid, out_sat;
  logic [1:0] out_ch;
  logic [7:0] out_data, rd_data;

  iob_acc_bank #(.N_CH(4), .CH_W(2), .DATA_W(8), .INCR_W(8), .RST_VAL(8'd0)) dut (
    .clk_i(clk), .cke_i(cke), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_ch_i(in_ch), .in_incr_i(in_incr),
    .dump_i(dump), .busy_o(busy),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_ch_o(out_ch),
    .out_data_o(out_data), .out_sat_o(out_sat),
    .rd_ch_i(rd_ch), .rd_data_o(rd_data)
  );

  always #5 clk = ~clk;

  // Model state: plain per-channel totals plus the dump cursor.
  int m_acc [N];
  bit m_sat [N];
  bit m_busy;
  int m_idx;
`ifdef IOB_ACC_BANK_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int s;
    if (!cke) return;
    if (rst) begin
      for (int c = 0; c < N; c++) begin m_acc[c] = 0; m_sat[c] = 0; end
      m_busy = 0; m_idx = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        s = m_acc[in_ch] + int'(in_incr);
        if (s > 255) begin
          if (SAT) begin m_acc[in_ch] = 255; m_sat[in_ch] = 1; end
          else m_acc[in_ch] = s - 256;
        end else m_acc[in_ch] = s;
      end
      if (dump) begin m_busy = 1; m_idx = 0; end
    end else if (out_ready) begin
      m_acc[m_idx] = 0; m_sat[m_idx] = 0;
      if (m_idx == N-1) begin m_busy = 0; m_idx = 0; end
      else m_idx++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", int'(in_ready), int'(!m_busy));
      chk("busy", int'(busy), int'(m_busy));
      chk("out_valid", int'(out_valid), int'(m_busy));
      chk("rd_data", int'(rd_data), m_acc[rd_ch]);
      if (m_busy) begin
        chk("out_ch", int'(out_ch), m_idx);
        chk("out_data", int'(out_data), m_acc[m_idx]);
        chk("out_sat", int'(out_sat), int'(m_sat[m_idx]));
      end
    end
  end

  task automatic acc_in(input int ch, input int v);
    in_valid = 1; in_ch = 2'(ch); in_incr = 8'(v);
    cycle();
    in_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1; cke = 1; cycle(); rst = 0;
  endtask

  task automatic peek(input string name, input int ch, input int exp);
    rd_ch = 2'(ch); #1;
    chk(name, int'(rd_data), exp);
  endtask

  initial begin
    cke = 1; rst = 1; in_valid = 0; in_ch = 0; in_incr = 0;
    dump = 0; out_ready = 0; rd_ch = 0;
    for (int c = 0; c < N; c++) begin m_acc[c] = 0; m_sat[c] = 0; end
    m_busy = 0; m_idx = 0;
    cycle(); cycle();
    rst = 0; chk_en = 1;

    // 1: reset state, then increments under cke=0 are ignored
    for (int c = 0; c < N; c++) peek("rst_acc", c, 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(out_valid), 0);
    cke = 0;
    for (int i = 0; i < 4; i++) acc_in(i, 50);
    dump = 1; cycle(); dump = 0;
    cke = 1;
    for (int c = 0; c < N; c++) peek("cke_hold", c, 0);
    chk("cke_busy", int'(busy), 0);

    // 2: back-to-back same-channel accepts
    in_valid = 1; in_ch = 1; in_incr = 5;
    cycle(); cycle(); cycle();
    in_ch = 3; in_incr = 7; cycle(); in_valid = 0;
    peek("b2b_ch1", 1, 15);
    peek("b2b_ch3", 3, 7);
    peek("b2b_ch0", 0, 0);
    peek("b2b_ch2", 2, 0);

    // 3: overflow on ch2
    acc_in(2, 200); acc_in(2, 100);
    peek("ovf_ch2", 2, SAT ? 255 : 44);
    dump = 1; cycle(); dump = 0;
    out_ready = 1;
    for (int c = 0; c < N; c++) begin
      #1 chk("ovf_sat", int'(out_sat), (SAT && c == 2) ? 1 : 0);
      cycle();
    end
    out_ready = 0;

    // 4: dump with stalls, increments ignored while busy
    do_reset();
    for (int c = 0; c < N; c++) acc_in(c, c + 1);
    dump = 1; cycle(); dump = 0;
    chk("d4_first", int'(out_data), 1);
    for (int i = 0; i < 16 && m_busy; i++) begin
      out_ready = (i % 4 == 0 || i % 4 == 3);
      in_valid = 1; in_ch = 2'(i); in_incr = 8'd33;
      cycle();
    end
    in_valid = 0; out_ready = 0;
    for (int c = 0; c < N; c++) peek("d4_clear", c, 0);
    chk("d4_busy", int'(busy), 0);
    chk("d4_ready", int'(in_ready), 1);

    // 5: dump in the same cycle as an accept
    acc_in(0, 1);
    in_valid = 1; in_ch = 0; in_incr = 9; dump = 1;
    cycle();
    in_valid = 0; dump = 0;
    chk("d5_ch", int'(out_ch), 0);
    chk("d5_data", int'(out_data), 10);
    out_ready = 1;
    for (int c = 0; c < N; c++) cycle();
    out_ready = 0;

    // 6: reset mid-dump at idx 2
    for (int c = 0; c < N; c++) acc_in(c, 20 + c);
    dump = 1; cycle(); dump = 0;
    out_ready = 1; cycle(); cycle(); out_ready = 0;
    chk("d6_idx", int'(out_ch), 2);
    cycle();
    rst = 1; cycle(); rst = 0;
    chk("d6_valid", int'(out_valid), 0);
    chk("d6_busy", int'(busy), 0);
    for (int c = 0; c < N; c++) peek("d6_clear", c, 0);
    acc_in(2, 4);
    dump = 1; cycle(); dump = 0;
    chk("d6_restart", int'(out_ch), 0);
    out_ready = 1;
    for (int c = 0; c < N; c++) cycle();
    out_ready = 0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cke       = ($urandom_range(0, 9) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = $urandom_range(0, 1);
      in_ch     = 2'($urandom_range(0, 3));
      in_incr   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 40));
      dump      = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rd_ch     = 2'($urandom_range(0, 3));
      cycle();
    end
    cke = 1; rst = 0; in_valid = 0; dump = 0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
